rgb_sinp: RTL

RGB_SINP -- requirements
Module: rgb_sinp

---
 rtl/rgb_sinp_pkg.sv | 40 ++++
 rtl/sig_sync.sv | 18 +
 rtl/rgb_sinp.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/rgb_sinp_pkg.sv
// Shared WS2812b word layout and default timing constants for the serial
// input (rgb_sinp) and output (rgb_sotp) blocks.
package rgb_sinp_pkg;

    localparam int WORD_W    = 32;
    localparam int BIT_VALID = 31;
    localparam int BIT_SRST  = 30;
    localparam int G_HI      = 23;
    localparam int G_LO      = 16;
    localparam int R_HI      = 15;
    localparam int R_LO      = 8;
    localparam int B_HI      = 7;
    localparam int B_LO      = 0;

    localparam int DEF_THRESH_H    = 58;
    localparam int DEF_TMIN_H      = 10;
    localparam int DEF_TMAX_H      = 150;
    localparam int DEF_STR_RST     = 4800;
    localparam int DEF_COUNTER_MAX = 7800;

    localparam logic [WORD_W-1:0] SRST_WORD = 32'hC000_0000;

    typedef enum logic [1:0] {
        SYNC      = 2'd0,
        IDLE_LOW  = 2'd1,
        MEAS_HIGH = 2'd2,
        MEAS_LOW  = 2'd3
    } rgb_state_e;

    function automatic logic [WORD_W-1:0] pixel_word(input logic [23:0] grb);
        logic [WORD_W-1:0] w;
        w            = '0;
        w[BIT_VALID] = 1'b1;
        w[G_HI:G_LO] = grb[23:16];
        w[R_HI:R_LO] = grb[15:8];
        w[B_HI:B_LO] = grb[7:0];
        return w;
    endfunction

endpackage

// File: rtl/sig_sync.sv
// Two-flop synchronizer for a single asynchronous input.
module sig_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff <= 2'b00;
        else        ff <= {ff[0], d};
    end

    assign q = ff[1];

endmodule

// File: rtl/rgb_sinp.sv
// WS2812b serial decoder: measures high/low times on the synchronized line
// and pushes 24-bit GRB pixels and stream-reset markers into a FIFO.
module rgb_sinp
    import rgb_sinp_pkg::*;
#(
    parameter int RGB_THRESH_H = DEF_THRESH_H,
    parameter int RGB_TMIN_H   = DEF_TMIN_H,
    parameter int RGB_TMAX_H   = DEF_TMAX_H,
    parameter int RGB_STR_RST  = DEF_STR_RST,
    parameter int COUNTER_MAX  = DEF_COUNTER_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_sig,
    input  logic              in_wr_fifo_full,
    output logic              out_wr_fifo_en,
    output logic [WORD_W-1:0] out_wr_fifo_data,
    output logic              out_ovfl,
    output logic              out_frame_err
);

    localparam int CW = $clog2(COUNTER_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(COUNTER_MAX);
    localparam logic [CW-1:0] STR_M1  = CW'(RGB_STR_RST - 1);
    localparam logic [CW-1:0] TMAX_M1 = CW'(RGB_TMAX_H - 1);
    localparam logic [CW-1:0] TMIN    = CW'(RGB_TMIN_H);
    localparam logic [CW-1:0] THRESH  = CW'(RGB_THRESH_H);

    rgb_state_e        state, state_nxt;
    logic              sig_s, sig_d, rise, fall;
    logic [CW-1:0]     cnt;
    logic [4:0]        bit_cnt;
    logic [23:0]       sh, sh_nxt;
    logic              cnt_clr, frame_evt, srst_evt, shift_en, bit_val, last_bit;
    logic              wr_req;
    logic [WORD_W-1:0] wr_word;

    sig_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (in_sig),
        .q     (sig_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sig_d <= 1'b0;
        else        sig_d <= sig_s;
    end

    assign rise = sig_s & ~sig_d;
    assign fall = ~sig_s & sig_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SYNC;
        else        state <= state_nxt;
    end

    // Decode events; the count measures the current level since the last edge.
    always_comb begin
        cnt_clr   = 1'b0;
        frame_evt = 1'b0;
        srst_evt  = 1'b0;
        shift_en  = 1'b0;
        case (state)
            SYNC: cnt_clr = sig_s;
            IDLE_LOW, MEAS_LOW: begin
                if (rise)                           cnt_clr  = 1'b1;
                else if (!sig_s && cnt == STR_M1)   srst_evt = 1'b1;
            end
            MEAS_HIGH: begin
                if (fall) begin
                    cnt_clr = 1'b1;
                    if (cnt < TMIN) frame_evt = 1'b1;
                    else            shift_en  = 1'b1;
                end else if (cnt == TMAX_M1) begin
                    cnt_clr   = 1'b1;
                    frame_evt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SYNC:               if (!sig_s && cnt == STR_M1) state_nxt = IDLE_LOW;
            IDLE_LOW, MEAS_LOW: begin
                if (rise)          state_nxt = MEAS_HIGH;
                else if (srst_evt) state_nxt = IDLE_LOW;
            end
            MEAS_HIGH: begin
                if (frame_evt)     state_nxt = SYNC;
                else if (shift_en) state_nxt = MEAS_LOW;
            end
            default:               state_nxt = SYNC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              cnt <= '0;
        else if (cnt_clr)        cnt <= '0;
        else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end

    assign bit_val  = (cnt >= THRESH);
    assign last_bit = (bit_cnt == 5'd23);
    assign sh_nxt   = {sh[22:0], bit_val};
    assign wr_req   = srst_evt | (shift_en & last_bit);
    assign wr_word  = srst_evt ? SRST_WORD : pixel_word(sh_nxt);

    // Full is sampled in the decision cycle; the strobe is registered so the
    // FIFO sees a clean one-cycle pulse with data already stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_wr_fifo_en   <= 1'b0;
            out_wr_fifo_data <= '0;
            out_ovfl         <= 1'b0;
            out_frame_err    <= 1'b0;
            sh               <= '0;
            bit_cnt          <= '0;
        end else begin
            out_wr_fifo_en <= 1'b0;
            if (wr_req) begin
                if (in_wr_fifo_full) begin
                    out_ovfl <= 1'b1;
                end else begin
                    out_wr_fifo_en   <= 1'b1;
                    out_wr_fifo_data <= wr_word;
                end
            end
            if (frame_evt || srst_evt) begin
                if (frame_evt || bit_cnt != 5'd0) out_frame_err <= 1'b1;
                sh      <= '0;
                bit_cnt <= '0;
            end else if (shift_en) begin
                if (last_bit) begin
                    sh      <= '0;
                    bit_cnt <= '0;
                end else begin
                    sh      <= sh_nxt;
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

endmodule
